// File: rtl/session_streak_counter.sv
// Session streak counter: counts successes toward a programmable target, clears on failure, tracks best streak.
// Latency: one edge from sampled event to count/best/done_pulse; out is combinational from count and target.
// Backpressure: none; every sampled event is consumed in the cycle it is seen.
module session_streak_counter #(
    parameter int WIDTH = 4,
    parameter int MODE  = 0,
    parameter int EDGE  = 1
) (
    input  logic             clk,
    input  logic             start,
    input  logic             c,
    input  logic             fail,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] best,
    output logic             out,
    output logic             done_pulse
);

    localparam bit HOLD_MODE = (MODE != 0);
    localparam bit EDGE_DET  = (EDGE != 0);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic             c_q, fail_q;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] best_q, best_d;
    logic             done_q, done_d;
    logic             succ, flt;
    logic             reached_cur, reached_nxt;

    assign succ = EDGE_DET ? (c & ~c_q) : c;
    assign flt  = EDGE_DET ? (fail & ~fail_q) : fail;

    assign reached_cur = (target != '0) && (count_q >= target);
    assign reached_nxt = (target != '0) && (count_d >= target);

    always_comb begin
        count_d = count_q;
        // A failure while holding a reached streak is ignored; the success branch then leaves count alone too.
        if (flt && !(HOLD_MODE && reached_cur)) begin
            count_d = '0;
        end else if (succ) begin
            if (!reached_cur) begin
                if (target != '0 || count_q != ALL_ONES) begin
                    count_d = count_q + 1'b1;
                end
            end else if (!HOLD_MODE) begin
                count_d = '0;
            end
        end
        done_d = reached_nxt && !reached_cur;
        best_d = (count_d > best_q) ? count_d : best_q;
    end

    always_ff @(posedge clk) begin
        c_q    <= c;
        fail_q <= fail;
        if (start) begin
            count_q <= '0;
            best_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            best_q  <= best_d;
            done_q  <= done_d;
        end
    end

    assign count      = count_q;
    assign best       = best_q;
    assign out        = reached_cur;
    assign done_pulse = done_q;

endmodule

// File: tb/tb_session_streak_counter.sv
// Bench for session_streak_counter: four parameter variants share c/fail/start, each with its own target.
module tb_session_streak_counter;

    logic       clk = 1'b0;
    logic       start = 1'b1;
    logic       c = 1'b0;
    logic       fail = 1'b0;
    logic [3:0] tA = 4'd4, tB = 4'd3, tC = 4'd0;
    logic [1:0] tD = 2'd0;

    logic [3:0] cntA, bstA, cntB, bstB, cntC, bstC;
    logic [1:0] cntD, bstD;
    logic       outA, outB, outC, outD, dA, dB, dC, dD;

    always #5 clk = ~clk;

    session_streak_counter #(.WIDTH(4), .MODE(0), .EDGE(1)) u_a (
        .clk(clk), .start(start), .c(c), .fail(fail), .target(tA),
        .count(cntA), .best(bstA), .out(outA), .done_pulse(dA));
    session_streak_counter #(.WIDTH(4), .MODE(1), .EDGE(1)) u_b (
        .clk(clk), .start(start), .c(c), .fail(fail), .target(tB),
        .count(cntB), .best(bstB), .out(outB), .done_pulse(dB));
    session_streak_counter #(.WIDTH(4), .MODE(0), .EDGE(0)) u_c (
        .clk(clk), .start(start), .c(c), .fail(fail), .target(tC),
        .count(cntC), .best(bstC), .out(outC), .done_pulse(dC));
    session_streak_counter #(.WIDTH(2), .MODE(0), .EDGE(1)) u_d (
        .clk(clk), .start(start), .c(c), .fail(fail), .target(tD),
        .count(cntD), .best(bstD), .out(outD), .done_pulse(dD));

    int total = 0;
    int bad = 0;

    // Reference model: per-variant streak state held as plain integers.
    int m_hold[4] = '{0, 1, 0, 0};
    int m_edge[4] = '{1, 1, 0, 1};
    int m_max[4]  = '{15, 15, 15, 3};
    int mc[4] = '{0, 0, 0, 0};
    int mb[4] = '{0, 0, 0, 0};
    int md[4] = '{0, 0, 0, 0};
    int prev_c = 0;
    int prev_f = 0;

    function automatic int tgt_of(int i);
        case (i)
            0: return int'(tA);
            1: return int'(tB);
            2: return int'(tC);
            default: return int'(tD);
        endcase
    endfunction

    function automatic int hit(int cnt, int t);
        return (t != 0 && cnt >= t) ? 1 : 0;
    endfunction

    task automatic model_edge();
        int ci = int'(c);
        int fi = int'(fail);
        for (int i = 0; i < 4; i++) begin
            if (start) begin
                mc[i] = 0; mb[i] = 0; md[i] = 0;
            end else begin
                int t = tgt_of(i);
                int s = m_edge[i] != 0 ? (ci & ~prev_c & 1) : ci;
                int f = m_edge[i] != 0 ? (fi & ~prev_f & 1) : fi;
                int was = hit(mc[i], t);
                int n = mc[i];
                if (f != 0 && !(m_hold[i] != 0 && was != 0)) n = 0;
                else if (s != 0) begin
                    if (was == 0) n = (n + 1 > m_max[i]) ? m_max[i] : n + 1;
                    else if (m_hold[i] == 0) n = 0;
                end
                md[i] = (hit(n, t) != 0 && was == 0) ? 1 : 0;
                if (n > mb[i]) mb[i] = n;
                mc[i] = n;
            end
        end
        prev_c = ci;
        prev_f = fi;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("A.count", int'(cntA), mc[0]); chk("A.best", int'(bstA), mb[0]);
        chk("A.out", int'(outA), hit(mc[0], tgt_of(0))); chk("A.done", int'(dA), md[0]);
        chk("B.count", int'(cntB), mc[1]); chk("B.best", int'(bstB), mb[1]);
        chk("B.out", int'(outB), hit(mc[1], tgt_of(1))); chk("B.done", int'(dB), md[1]);
        chk("C.count", int'(cntC), mc[2]); chk("C.best", int'(bstC), mb[2]);
        chk("C.out", int'(outC), hit(mc[2], tgt_of(2))); chk("C.done", int'(dC), md[2]);
        chk("D.count", int'(cntD), mc[3]); chk("D.best", int'(bstD), mb[3]);
        chk("D.out", int'(outD), hit(mc[3], tgt_of(3))); chk("D.done", int'(dD), md[3]);
    endtask

    typedef struct {
        bit st; bit cc; bit ff; int tgt;
        int cnt; int o; int d; int bst;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Variant A (WRAP, edge): basic count, wrap, fail priority, target lowering.
        tbl.push_back('{1, 0, 0, 4, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 4, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 4, 1, 0, 0, 1});
        tbl.push_back('{0, 1, 0, 4, 2, 0, 0, 2});
        tbl.push_back('{0, 0, 0, 4, 2, 0, 0, 2});
        tbl.push_back('{0, 1, 0, 4, 3, 0, 0, 3});
        tbl.push_back('{0, 0, 0, 4, 3, 0, 0, 3});
        tbl.push_back('{0, 1, 0, 4, 4, 1, 1, 4});
        tbl.push_back('{0, 0, 0, 4, 4, 1, 0, 4});
        tbl.push_back('{0, 1, 0, 4, 0, 0, 0, 4});
        tbl.push_back('{1, 0, 0, 4, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 4, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 4, 1, 0, 0, 1});
        tbl.push_back('{0, 1, 0, 4, 2, 0, 0, 2});
        tbl.push_back('{0, 0, 0, 4, 2, 0, 0, 2});
        tbl.push_back('{0, 1, 1, 4, 0, 0, 0, 2});
        tbl.push_back('{0, 0, 0, 5, 0, 0, 0, 2});
        tbl.push_back('{0, 1, 0, 5, 1, 0, 0, 2});
        tbl.push_back('{0, 0, 0, 5, 1, 0, 0, 2});
        tbl.push_back('{0, 1, 0, 5, 2, 0, 0, 2});
        tbl.push_back('{0, 0, 0, 5, 2, 0, 0, 2});
        tbl.push_back('{0, 1, 0, 5, 3, 0, 0, 3});
        tbl.push_back('{0, 0, 0, 2, 3, 1, 0, 3});
        tbl.push_back('{0, 1, 0, 2, 0, 0, 0, 3});

        #1;
        foreach (tbl[k]) begin
            start = tbl[k].st; c = tbl[k].cc; fail = tbl[k].ff; tA = 4'(tbl[k].tgt);
            if (k == 22) begin
                #1;
                chk("A.out_immediate", int'(outA), 1);
            end
            tick();
            chk($sformatf("A.count[%0d]", k), int'(cntA), tbl[k].cnt);
            chk($sformatf("A.out[%0d]", k), int'(outA), tbl[k].o);
            chk($sformatf("A.done[%0d]", k), int'(dA), tbl[k].d);
            chk($sformatf("A.best[%0d]", k), int'(bstA), tbl[k].bst);
        end

        // HOLD on variant B, target 3.
        c = 0; fail = 0; start = 1; tB = 4'd3; tick(); start = 0;
        for (int p = 1; p <= 3; p++) begin
            c = 1; tick();
            chk("B.hold_count", int'(cntB), p);
            chk("B.hold_done", int'(dB), (p == 3) ? 1 : 0);
            c = 0; tick();
        end
        chk("B.hold_out", int'(outB), 1);
        chk("B.hold_done_low", int'(dB), 0);
        c = 1; tick(); c = 0; tick();
        chk("B.hold_after_c", int'(cntB), 3);
        fail = 1; tick(); fail = 0; tick();
        chk("B.hold_after_fail", int'(cntB), 3);
        chk("B.hold_out_kept", int'(outB), 1);
        start = 1; tick(); start = 0;
        chk("B.start_count", int'(cntB), 0);
        chk("B.start_best", int'(bstB), 0);
        chk("B.start_out", int'(outB), 0);
        chk("B.start_done", int'(dB), 0);

        // Edge vs level: c held five cycles; then c held through reset deassertion.
        tA = 4'd0; tC = 4'd0; start = 1; tick(); start = 0;
        c = 1;
        for (int k = 0; k < 5; k++) tick();
        chk("A.edge_held", int'(cntA), 1);
        chk("C.level_held", int'(cntC), 5);
        start = 1; tick(); start = 0;
        for (int k = 0; k < 3; k++) tick();
        chk("A.held_through_reset", int'(cntA), 0);
        chk("C.level_after_reset", int'(cntC), 3);
        c = 0; tick();

        // Saturation on 2-bit variant D with target disabled.
        tD = 2'd0; start = 1; tick(); start = 0;
        for (int p = 1; p <= 6; p++) begin
            c = 1; tick();
            chk("D.sat_count", int'(cntD), (p > 3) ? 3 : p);
            chk("D.sat_out", int'(outD), 0);
            chk("D.sat_done", int'(dD), 0);
            c = 0; tick();
        end

        // Randomized run against the model.
        start = 1; c = 0; fail = 0; tick();
        for (int k = 0; k < 4000 && bad < 40; k++) begin
            c = 1'($urandom_range(0, 1));
            fail = ($urandom_range(0, 11) == 0);
            start = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 29) == 0) tA = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) tB = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) tC = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) tD = 2'($urandom_range(0, 3));
            tick();
            chk_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
